// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
// Bus width, request size encoding, reset fetch address and beat word select.
package ifu_prefetch_pkg;

    localparam int          BUS_64       = 64;
    localparam logic [1:0]  SIZE_W       = 2'b10;
    localparam logic [63:0] PC_START_DEF = 64'h8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    function automatic logic [31:0] word_sel(
        input logic              hi,
        input logic [BUS_64-1:0] beat
    );
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on o_dout while count != 0.
// Flush clears pointers and count; push when full and pop when empty are ignored.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & (r_count != CW'(DEPTH));
    assign w_pop   = i_pop & (r_count != '0);
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential 32-bit fetches into a prefetch queue,
// with redirect flush, 64-bit beat word select and halt on bus error.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(PC_START_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_axi_valid,
    input  logic              i_axi_ready,
    input  logic [63:0]       i_axi_data_read,
    input  logic [1:0]        i_axi_resp,
    output logic [ADDR_W-1:0] o_axi_addr,
    output logic [1:0]        o_axi_size,
    input  logic              i_pc_jmp,
    input  logic [ADDR_W-1:0] i_pc_jmpaddr,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_pred,
    output logic [31:0]       o_inst,
    output logic              o_inst_err,
    output logic              fetched_pulse
);

    localparam int PW = ADDR_W + 33;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_addr;
    logic              r_halt;
    logic [PW-1:0]     r_last;
    logic [PW-1:0]     w_din;
    logic [PW-1:0]     w_head;
    logic [PW-1:0]     w_out;
    logic [CW-1:0]     w_count;
    logic              w_err;
    logic              w_push;
    logic              w_pop;

    assign w_err  = i_axi_resp != RESP_OKAY;
    assign w_din  = {w_err, word_sel(r_addr[2], i_axi_data_read), r_addr};

    assign o_axi_valid   = (w_count < CW'(DEPTH)) & ~r_halt;
    assign w_push        = o_axi_valid & i_axi_ready & ~i_pc_jmp;
    assign fetched_pulse = w_push;
    assign o_axi_addr    = r_addr;
    assign o_axi_size    = SIZE_W;

    assign o_inst_valid = w_count != '0;
    assign w_pop        = o_inst_valid & i_inst_ready & ~i_pc_jmp;

    // Empty queue shows the most recently consumed entry.
    assign w_out      = o_inst_valid ? w_head : r_last;
    assign o_pc       = w_out[ADDR_W-1:0];
    assign o_inst     = w_out[ADDR_W+31:ADDR_W];
    assign o_inst_err = w_out[PW-1];
    assign o_pc_pred  = o_pc + ADDR_W'(4);

    ifu_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_pc_jmp),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= PC_START;
            r_halt <= 1'b0;
            r_last <= '0;
        end else if (i_pc_jmp) begin
            r_addr <= {i_pc_jmpaddr[ADDR_W-1:2], 2'b00};
            r_halt <= 1'b0;
        end else begin
            if (w_push) begin
                r_addr <= r_addr + ADDR_W'(4);
                if (w_err) r_halt <= 1'b1;
            end
            if (w_pop) r_last <= w_head;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized scoreboard bench for ifu_prefetch against a queue-based model.
// Driver predicts pushes into a queue; a monitor pops and checks the head.
module tb_ifu_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [63:0] PCS   = 64'h8000_0000;
    localparam int          NCYC  = 4000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_axi_valid;
    logic        i_axi_ready;
    logic [63:0] i_axi_data_read;
    logic [1:0]  i_axi_resp;
    logic [63:0] o_axi_addr;
    logic [1:0]  o_axi_size;
    logic        i_pc_jmp;
    logic [63:0] i_pc_jmpaddr;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [63:0] o_pc;
    logic [63:0] o_pc_pred;
    logic [31:0] o_inst;
    logic        o_inst_err;
    logic        fetched_pulse;

    always #5 i_clk = ~i_clk;

    ifu_prefetch #(
        .ADDR_W   (64),
        .DEPTH    (DEPTH),
        .PC_START (PCS)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .o_axi_valid     (o_axi_valid),
        .i_axi_ready     (i_axi_ready),
        .i_axi_data_read (i_axi_data_read),
        .i_axi_resp      (i_axi_resp),
        .o_axi_addr      (o_axi_addr),
        .o_axi_size      (o_axi_size),
        .i_pc_jmp        (i_pc_jmp),
        .i_pc_jmpaddr    (i_pc_jmpaddr),
        .o_inst_valid    (o_inst_valid),
        .i_inst_ready    (i_inst_ready),
        .o_pc            (o_pc),
        .o_pc_pred       (o_pc_pred),
        .o_inst          (o_inst),
        .o_inst_err      (o_inst_err),
        .fetched_pulse   (fetched_pulse)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    ent_t        sb[$];
    ent_t        m_last;
    logic [63:0] m_addr;
    logic        m_halt;
    int          total = 0;
    int          bad = 0;
    bit          run = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: head of the expected queue must match what decode sees.
    initial begin
        ent_t e;
        forever begin
            @(posedge i_clk);
            #3;
            if (run) begin
                chk("inst_valid", 64'(o_inst_valid), 64'(sb.size() != 0));
                e = (sb.size() != 0) ? sb[0] : m_last;
                chk("pc", o_pc, e.pc);
                chk("inst", 64'(o_inst), 64'(e.inst));
                chk("inst_err", 64'(o_inst_err), 64'(e.err));
                chk("pc_pred", o_pc_pred, e.pc + 64'd4);
                if (!i_rst && !i_pc_jmp && i_inst_ready && sb.size() != 0)
                    m_last = sb.pop_front();
            end
        end
    end

    initial begin
        bit   exp_v;
        bit   exp_push;
        ent_t e;
        i_rst = 1'b1;
        i_axi_ready = 1'b0;
        i_axi_data_read = '0;
        i_axi_resp = 2'b00;
        i_pc_jmp = 1'b0;
        i_pc_jmpaddr = '0;
        i_inst_ready = 1'b0;
        m_addr = PCS;
        m_halt = 1'b0;
        m_last = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        chk("rst_addr", o_axi_addr, PCS);
        chk("rst_axi_valid", 64'(o_axi_valid), 64'd1);
        chk("rst_inst_valid", 64'(o_inst_valid), 64'd0);
        chk("rst_pc", o_pc, 64'd0);
        chk("rst_inst", 64'(o_inst), 64'd0);
        run = 1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge i_clk);
            #1;
            i_axi_data_read = {$urandom, $urandom};
            if ($urandom_range(7, 0) == 0)
                i_pc_jmpaddr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            else
                i_pc_jmpaddr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            if (cyc < 20) begin
                i_axi_ready = 1'b1;
                i_inst_ready = 1'b0;
                i_pc_jmp = 1'b0;
                i_axi_resp = 2'b00;
                i_rst = 1'b0;
            end else if (cyc < 60) begin
                i_axi_ready = 1'b1;
                i_inst_ready = (cyc >= 30);
                i_pc_jmp = (cyc == 24);
                if (cyc == 24) i_pc_jmpaddr = 64'h8000_1002;
                i_axi_resp = (cyc == 45) ? 2'b10 : 2'b00;
                i_rst = 1'b0;
            end else begin
                i_axi_ready = $urandom_range(99, 0) < 60;
                i_inst_ready = $urandom_range(99, 0) < 50;
                i_pc_jmp = $urandom_range(99, 0) < 5;
                i_axi_resp = ($urandom_range(99, 0) < 5) ?
                             2'($urandom_range(3, 1)) : 2'b00;
                i_rst = $urandom_range(199, 0) == 0;
            end
            #1;
            exp_v = (sb.size() < DEPTH) && !m_halt;
            exp_push = exp_v && i_axi_ready && !i_pc_jmp;
            chk("axi_valid", 64'(o_axi_valid), 64'(exp_v));
            chk("axi_addr", o_axi_addr, m_addr);
            chk("axi_size", 64'(o_axi_size), 64'd2);
            chk("fetched_pulse", 64'(fetched_pulse), 64'(exp_push));
            #2;
            if (i_rst) begin
                sb.delete();
                m_addr = PCS;
                m_halt = 1'b0;
                m_last = '0;
            end else if (i_pc_jmp) begin
                sb.delete();
                m_addr = i_pc_jmpaddr & ~64'd3;
                m_halt = 1'b0;
            end else if (exp_push) begin
                e.pc = m_addr;
                e.inst = 32'(i_axi_data_read >> (m_addr[2] ? 32 : 0));
                e.err = i_axi_resp != 2'b00;
                sb.push_back(e);
                m_addr = m_addr + 64'd4;
                if (e.err) m_halt = 1'b1;
            end
        end
        @(posedge i_clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
